reg_file_arb: RTL and testbench

// - Two-requester arbiter and sequencer in front of the 2x16-bit register file.
// - The register file has one read port, one full-width write port (32 bits,

---
 rtl/reg_file_arb_pkg.sv | 22 ++
 rtl/reg_file_arb_if.sv | 38 +++
 rtl/reg_file_arb_rr_arb2.sv | 16 +
 rtl/reg_file_arb.sv | 93 +++++++++
 tb/tb_reg_file_arb.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_arb_pkg.sv
// Shared constants, FSM state encoding and a small helper for the
// two-requester register file arbiter.
package reg_file_arb_pkg;

    localparam int DATA_W  = 16;
    localparam int NREG    = 2;
    localparam int ADDR_W  = 1;
    localparam int WDATA_W = NREG * DATA_W;

    // 2'd3 is never entered; the FSM treats it as a request to return to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RESP   = 2'd2,
        ST_UNUSED = 2'd3
    } state_t;

    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/reg_file_arb_if.sv
// Request/response channels of both requesters plus the register file port,
// bundled so the arbiter and its environment share one definition.
interface reg_file_arb_if;
    import reg_file_arb_pkg::*;

    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [1:0]         req_write;
    logic [1:0]         req_addr;
    logic [WDATA_W-1:0] req_wdata0;
    logic [WDATA_W-1:0] req_wdata1;

    logic [1:0]         resp_valid;
    logic [1:0]         resp_ready;
    logic [DATA_W-1:0]  resp_rdata;

    logic [ADDR_W-1:0]  rf_raddr;
    logic               rf_wen;
    logic [WDATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0]  rf_rdata;

    // The arbiter side.
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata0, req_wdata1,
        input  resp_ready, rf_rdata,
        output req_ready, resp_valid, resp_rdata,
        output rf_raddr, rf_wen, rf_wdata
    );

    // The requesters plus register file side.
    modport master (
        output req_valid, req_write, req_addr, req_wdata0, req_wdata1,
        output resp_ready, rf_rdata,
        input  req_ready, resp_valid, resp_rdata,
        input  rf_raddr, rf_wen, rf_wdata
    );

endinterface

// File: rtl/reg_file_arb_rr_arb2.sv
// Two-input round-robin grant: a lone requester always wins, a tie goes to
// the requester named by prio_i.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       prio_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = valid_i;
        if (valid_i == 2'b11) begin
            grant_o = prio_i ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/reg_file_arb.sv
// Arbitrates two requesters onto a single-port 2x16 register file, running
// one operation at a time through IDLE -> ISSUE -> RESP.
module reg_file_arb
    import reg_file_arb_pkg::*;
(
    input logic           clock,
    input logic           reset,
    reg_file_arb_if.slave bus
);

    state_t             state_q;
    logic               prio_q;
    logic               owner_q;
    logic               write_q;
    logic [1:0]         resp_valid_q;
    logic [DATA_W-1:0]  resp_rdata_q;
    logic               rf_wen_q;
    logic [ADDR_W-1:0]  rf_raddr_q;
    logic [WDATA_W-1:0] rf_wdata_q;

    logic [1:0]         grant;
    logic               winner;
    logic               accept;
    logic [WDATA_W-1:0] wdata_sel;

    rr_arb2 u_rr_arb2 (
        .valid_i (bus.req_valid),
        .prio_i  (prio_q),
        .grant_o (grant)
    );

    always_comb begin
        winner    = grant[1];
        wdata_sel = grant[1] ? bus.req_wdata1 : bus.req_wdata0;
        accept    = (state_q == ST_IDLE) && !reset && (grant != 2'b00);
    end

    // Ready is only offered to the current winner while idle and out of reset.
    assign bus.req_ready  = ((state_q == ST_IDLE) && !reset) ? grant : 2'b00;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.rf_raddr   = rf_raddr_q;
    assign bus.rf_wen     = rf_wen_q;
    assign bus.rf_wdata   = rf_wdata_q;

    // The rf address/data registers double as the op latches, so they already
    // carry the right values when ISSUE begins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            prio_q       <= 1'b0;
            owner_q      <= 1'b0;
            write_q      <= 1'b0;
            resp_valid_q <= 2'b00;
            resp_rdata_q <= '0;
            rf_wen_q     <= 1'b0;
            rf_raddr_q   <= '0;
            rf_wdata_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        owner_q    <= winner;
                        write_q    <= bus.req_write[winner];
                        rf_raddr_q <= bus.req_addr[winner];
                        rf_wdata_q <= wdata_sel;
                        rf_wen_q   <= bus.req_write[winner];
                        prio_q     <= ~winner;
                        state_q    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    rf_wen_q     <= 1'b0;
                    resp_rdata_q <= write_q ? '0 : bus.rf_rdata;
                    resp_valid_q <= owner_onehot(owner_q);
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.resp_ready[owner_q]) begin
                        resp_valid_q <= 2'b00;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    rf_wen_q     <= 1'b0;
                    resp_valid_q <= 2'b00;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_arb.sv
// Directed bench for reg_file_arb with a cycle-level reference model of the
// arbiter and a behavioural 2x16 register file.
module tb_reg_file_arb;

    logic clock;
    logic reset;

    reg_file_arb_if bus ();

    reg_file_arb dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int assertCount = 0;
    int failCount   = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural register file: combinational read, write on the clock edge.
    logic [31:0] rfMem;
    initial rfMem = 32'h0;
    always @(posedge clock) begin
        if (bus.rf_wen === 1'b1) rfMem <= bus.rf_wdata;
    end
    assign bus.rf_rdata = bus.rf_raddr ? rfMem[31:16] : rfMem[15:0];

    // Observers used by the directed literal checks.
    int         wenCount = 0;
    logic [31:0] lastWdata = 32'h0;
    logic [1:0]  grantLog[$];
    bit          bothSeen = 1'b0;

    always @(negedge clock) begin
        if (bus.rf_wen === 1'b1) begin
            wenCount++;
            lastWdata = bus.rf_wdata;
        end
        if (bus.req_ready != 2'b00) grantLog.push_back(bus.req_ready);
        if (bus.req_ready == 2'b11) bothSeen = 1'b1;
    end

    // Reference model: tracks the op in flight by its age in cycles since the
    // accepting edge and the register contents as the requesters should see them.
    bit          mBusy = 1'b0;
    int          mAge = 0;
    logic        mPrio = 1'b0;
    logic        mOwner = 1'b0;
    logic        mWrite = 1'b0;
    logic        mAddr = 1'b0;
    logic [31:0] mWdata = 32'h0;
    logic [15:0] mExp = 16'h0;
    logic [15:0] mMem [2] = '{16'h0, 16'h0};

    always @(negedge clock) begin
        logic       win;
        logic [1:0] expReady;
        logic [1:0] expResp;
        if (reset) begin
            checkOutput("rst_req_ready", 32'(bus.req_ready), 32'h0);
            checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
            checkOutput("rst_rf_wen", 32'(bus.rf_wen), 32'h0);
            checkOutput("rst_resp_rdata", 32'(bus.resp_rdata), 32'h0);
            mBusy = 1'b0;
            mAge  = 0;
            mPrio = 1'b0;
        end else begin
            if (mBusy) mAge++;
            checkOutput("rf_wen", 32'(bus.rf_wen), 32'(mBusy && mAge == 1 && mWrite));
            if (mBusy && mAge == 1) begin
                checkOutput("rf_raddr", 32'(bus.rf_raddr), 32'(mAddr));
                if (mWrite) begin
                    checkOutput("rf_wdata", bus.rf_wdata, mWdata);
                    mMem[0] = mWdata[15:0];
                    mMem[1] = mWdata[31:16];
                    mExp    = 16'h0;
                end else begin
                    mExp = mMem[mAddr];
                end
            end
            expResp = (mBusy && mAge >= 2) ? (mOwner ? 2'b10 : 2'b01) : 2'b00;
            checkOutput("resp_valid", 32'(bus.resp_valid), 32'(expResp));
            if (mBusy && mAge >= 2) checkOutput("resp_rdata", 32'(bus.resp_rdata), 32'(mExp));
            if (bus.req_valid == 2'b11) win = mPrio;
            else                        win = bus.req_valid[1];
            expReady = (!mBusy && bus.req_valid != 2'b00) ? (win ? 2'b10 : 2'b01) : 2'b00;
            checkOutput("req_ready", 32'(bus.req_ready), 32'(expReady));
            if (mBusy && mAge >= 2 && bus.resp_ready[mOwner]) begin
                mBusy = 1'b0;
            end else if (!mBusy && bus.req_valid != 2'b00) begin
                mBusy  = 1'b1;
                mAge   = 0;
                mOwner = win;
                mWrite = bus.req_write[win];
                mAddr  = bus.req_addr[win];
                mWdata = win ? bus.req_wdata1 : bus.req_wdata0;
                mPrio  = ~win;
            end
        end
    end

    task automatic driveReq(input int who, input bit wr, input bit addr, input logic [31:0] wdata);
        bus.req_write[who] = wr;
        bus.req_addr[who]  = addr;
        if (who == 0) bus.req_wdata0 = wdata;
        else          bus.req_wdata1 = wdata;
        bus.req_valid[who] = 1'b1;
    endtask

    task automatic waitAccept(input int who);
        bit ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (bus.req_ready[who]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput("accept_timeout", 32'h0, 32'h1);
        @(posedge clock);
        #1 bus.req_valid[who] = 1'b0;
    endtask

    task automatic waitResp(input int hold, output logic [1:0] gotValid, output logic [15:0] gotData);
        bit ok = 1'b0;
        gotValid = 2'b00;
        gotData  = 16'h0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (bus.resp_valid != 2'b00) begin
                ok = 1'b1;
                gotValid = bus.resp_valid;
                gotData  = bus.resp_rdata;
                break;
            end
        end
        if (!ok) checkOutput("resp_timeout", 32'h0, 32'h1);
        repeat (hold) @(posedge clock);
        @(posedge clock);
        #1 bus.resp_ready = 2'b11;
        @(posedge clock);
        #1 bus.resp_ready = 2'b00;
    endtask

    task automatic applyStimulus(input int who, input bit wr, input bit addr, input logic [31:0] wdata,
                                 input logic [1:0] expValid, input logic [15:0] expData, input string name);
        logic [1:0]  v;
        logic [15:0] d;
        driveReq(who, wr, addr, wdata);
        waitAccept(who);
        waitResp(0, v, d);
        checkOutput({name, "_valid"}, 32'(v), 32'(expValid));
        checkOutput({name, "_rdata"}, 32'(d), 32'(expData));
    endtask

    task automatic pulseReset();
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        logic [1:0]  v;
        logic [15:0] d;
        bit          ok;

        reset           = 1'b1;
        bus.req_valid   = 2'b11;
        bus.req_write   = 2'b00;
        bus.req_addr    = 2'b00;
        bus.req_wdata0  = 32'h0;
        bus.req_wdata1  = 32'h0;
        bus.resp_ready  = 2'b00;

        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_req_ready", 32'(bus.req_ready), 32'h0);
        checkOutput("reset_rf_raddr", 32'(bus.rf_raddr), 32'h0);
        checkOutput("reset_rf_wdata", bus.rf_wdata, 32'h0);
        bus.req_valid = 2'b00;
        reset = 1'b0;

        $display("[TB] write then read-back");
        wenCount = 0;
        applyStimulus(0, 1'b1, 1'b0, 32'hBEEF_1234, 2'b01, 16'h0000, "w0");
        checkOutput("w0_wen_pulses", 32'(wenCount), 32'd1);
        checkOutput("w0_wdata", lastWdata, 32'hBEEF_1234);
        applyStimulus(1, 1'b0, 1'b1, 32'h0, 2'b10, 16'hBEEF, "r1_a1");

        $display("[TB] response back-pressure");
        wenCount = 0;
        driveReq(0, 1'b0, 1'b1, 32'h0);
        waitAccept(0);
        driveReq(1, 1'b0, 1'b0, 32'h0);
        waitResp(5, v, d);
        checkOutput("hold_valid", 32'(v), 32'h1);
        checkOutput("hold_rdata", 32'(d), 32'hBEEF);
        waitAccept(1);
        waitResp(0, v, d);
        checkOutput("after_hold_valid", 32'(v), 32'h2);
        checkOutput("after_hold_rdata", 32'(d), 32'h1234);
        checkOutput("hold_wen_pulses", 32'(wenCount), 32'd0);

        $display("[TB] fairness with both requesters valid");
        pulseReset();
        grantLog.delete();
        bothSeen = 1'b0;
        bus.req_write  = 2'b00;
        bus.req_addr   = 2'b10;
        bus.resp_ready = 2'b11;
        bus.req_valid  = 2'b11;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (grantLog.size() >= 4) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput("fair_timeout", 32'h0, 32'h1);
        @(posedge clock);
        #1 bus.req_valid = 2'b00;
        repeat (5) @(posedge clock);
        #1 bus.resp_ready = 2'b00;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] g;
            g = (grantLog.size() > i) ? grantLog[i] : 2'b00;
            checkOutput($sformatf("fair_grant%0d", i), 32'(g), (i % 2 == 0) ? 32'h1 : 32'h2);
        end
        checkOutput("fair_no_double_ready", 32'(bothSeen), 32'h0);

        $display("[TB] reset during a write issue");
        wenCount = 0;
        driveReq(0, 1'b1, 1'b0, 32'hDEAD_0000);
        waitAccept(0);
        #1 reset = 1'b1;
        #1;
        checkOutput("midrst_rf_wen", 32'(bus.rf_wen), 32'h0);
        checkOutput("midrst_resp_valid", 32'(bus.resp_valid), 32'h0);
        checkOutput("midrst_rf_wdata", bus.rf_wdata, 32'h0);
        driveReq(0, 1'b0, 1'b0, 32'h0);
        driveReq(1, 1'b0, 1'b1, 32'h0);
        repeat (2) @(posedge clock);
        grantLog.delete();
        #1 reset = 1'b0;
        waitAccept(0);
        checkOutput("midrst_first_grant", 32'((grantLog.size() > 0) ? grantLog[0] : 2'b00), 32'h1);
        waitResp(0, v, d);
        checkOutput("midrst_r0_valid", 32'(v), 32'h1);
        checkOutput("midrst_r0_rdata", 32'(d), 32'h1234);
        waitAccept(1);
        waitResp(0, v, d);
        checkOutput("midrst_r1_valid", 32'(v), 32'h2);
        checkOutput("midrst_r1_rdata", 32'(d), 32'hBEEF);
        checkOutput("midrst_wen_pulses", 32'(wenCount), 32'd0);
        checkOutput("midrst_rf_contents", rfMem, 32'hBEEF_1234);

        $display("[TB] read-after-write across requesters");
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_A5A5, 2'b10, 16'h0000, "w1");
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 2'b01, 16'hA5A5, "raw_a0");
        applyStimulus(0, 1'b0, 1'b1, 32'h0, 2'b01, 16'h0000, "raw_a1");

        repeat (3) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
